// File: rtl/vslc_output_shifter.sv
// Snapshot-and-serialize output stage for the VSLC core.
// Drives a 74HC595-style chain MSB-first, then latches once per scan cycle.
module vslc_output_shifter #(
  parameter int DATA_W  = 24,
  parameter int CLK_DIV = 2,
  parameter int OVR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             snap_req,
  input  logic [7:0]       out_in,
  input  logic [15:0]      stack_in,
  output logic             sr_data,
  output logic             sr_clk,
  output logic             sr_latch,
  output logic             busy,
  output logic             frame_done,
  output logic [OVR_W-1:0] overrun
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  localparam int DIV_W = 8;
  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_END  = DIV_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [OVR_W-1:0] OVR_MAX  = '1;

  state_t              state, state_n;
  logic [DIV_W-1:0]    div, div_n;
  logic [CNT_W-1:0]    bit_cnt, cnt_n;
  logic [DATA_W-1:0]   shreg, sh_n;
  logic                pend_v, pv_n;
  logic [DATA_W-1:0]   pend_w, pw_n;
  logic [OVR_W-1:0]    ovr, ovr_n;
  logic [DATA_W-1:0]   word;
  logic                done_w;
  logic                shifting;

  assign word     = {out_in, stack_in};
  assign done_w   = (state == LATCH) && (div == DIV_END);
  assign shifting = (state == SHIFT_LO) || (state == SHIFT_HI);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      pend_v  <= 1'b0;
      pend_w  <= '0;
      ovr     <= '0;
    end else begin
      state   <= state_n;
      div     <= div_n;
      bit_cnt <= cnt_n;
      shreg   <= sh_n;
      pend_v  <= pv_n;
      pend_w  <= pw_n;
      ovr     <= ovr_n;
    end
  end

  always_comb begin
    state_n = state;
    div_n   = div;
    cnt_n   = bit_cnt;
    sh_n    = shreg;
    pv_n    = pend_v;
    pw_n    = pend_w;
    ovr_n   = ovr;

    unique case (state)
      IDLE: begin
        if (snap_req) begin
          sh_n    = word;
          cnt_n   = CNT_LAST;
          div_n   = '0;
          state_n = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div == DIV_LAST) begin
          div_n   = '0;
          state_n = SHIFT_HI;
        end else begin
          div_n = div + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (div == DIV_LAST) begin
          div_n = '0;
          if (bit_cnt == '0) begin
            state_n = LATCH;
          end else begin
            sh_n    = {shreg[DATA_W-2:0], 1'b0};
            cnt_n   = bit_cnt - 1'b1;
            state_n = SHIFT_LO;
          end
        end else begin
          div_n = div + 1'b1;
        end
      end
      LATCH: begin
        if (div == DIV_END) begin
          div_n = '0;
          // A queued word starts here; a coincident request refills the queue.
          if (pend_v) begin
            sh_n    = pend_w;
            cnt_n   = CNT_LAST;
            state_n = SHIFT_LO;
            if (snap_req) begin
              pw_n = word;
            end else begin
              pv_n = 1'b0;
            end
          end else if (snap_req) begin
            sh_n    = word;
            cnt_n   = CNT_LAST;
            state_n = SHIFT_LO;
          end else begin
            state_n = IDLE;
          end
        end else begin
          div_n = div + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (snap_req && (state != IDLE) && !done_w) begin
      pw_n = word;
      if (pend_v) begin
        if (ovr != OVR_MAX) begin
          ovr_n = ovr + 1'b1;
        end
      end else begin
        pv_n = 1'b1;
      end
    end
  end

  assign sr_data    = shifting & shreg[DATA_W-1];
  assign sr_clk     = (state == SHIFT_HI);
  assign sr_latch   = (state == LATCH) && !done_w;
  assign frame_done = done_w;
  assign busy       = (state != IDLE);
  assign overrun    = ovr;

endmodule

// File: tb/tb_vslc_output_shifter.sv
// Bench for vslc_output_shifter: vector table, corner sequences,
// random traffic against a time-based reference model.
module tb_vslc_output_shifter;

  localparam int CD = 2;
  localparam int NB = 24;
  localparam int SH = 2 * CD * NB;
  localparam int FL = SH + CD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        snap_req = 1'b0;
  logic [7:0]  out_in = '0;
  logic [15:0] stack_in = '0;
  logic        sr_data, sr_clk, sr_latch, busy, frame_done;
  logic [7:0]  overrun;

  logic        rst2 = 1'b1;
  logic        snap2 = 1'b0;
  logic [7:0]  out2 = '0;
  logic [15:0] stk2 = '0;
  logic        d2, c2, l2, b2, dn2;
  logic [7:0]  ovr2;

  vslc_output_shifter #(.DATA_W(24), .CLK_DIV(CD), .OVR_W(8)) dut (
    .clk(clk), .rst(rst), .snap_req(snap_req),
    .out_in(out_in), .stack_in(stack_in),
    .sr_data(sr_data), .sr_clk(sr_clk), .sr_latch(sr_latch),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  vslc_output_shifter #(.DATA_W(24), .CLK_DIV(1), .OVR_W(8)) dut1 (
    .clk(clk), .rst(rst2), .snap_req(snap2),
    .out_in(out2), .stack_in(stk2),
    .sr_data(d2), .sr_clk(c2), .sr_latch(l2),
    .busy(b2), .frame_done(dn2), .overrun(ovr2)
  );

  int tests = 0;
  int fails = 0;
  int nprint = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: elapsed time since busy rose decides every output.
  logic        m_act = 1'b0;
  int          m_t = 0;
  logic [23:0] m_cur = '0;
  logic        m_pv = 1'b0;
  logic [23:0] m_pw = '0;
  int          m_ovr = 0;
  logic        chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_act = 1'b0; m_t = 0; m_pv = 1'b0; m_ovr = 0;
    end else if (!m_act) begin
      if (snap_req) begin
        m_act = 1'b1; m_t = 0; m_cur = {out_in, stack_in};
      end
    end else if (m_t == FL) begin
      if (m_pv) begin
        m_cur = m_pw; m_t = 0;
        if (snap_req) m_pw = {out_in, stack_in};
        else m_pv = 1'b0;
      end else if (snap_req) begin
        m_cur = {out_in, stack_in}; m_t = 0;
      end else begin
        m_act = 1'b0;
      end
    end else begin
      m_t++;
      if (snap_req) begin
        if (m_pv && m_ovr != 255) m_ovr++;
        m_pw = {out_in, stack_in};
        m_pv = 1'b1;
      end
    end
  end

  logic       e_data, e_clk, e_lat, e_done;
  logic [4:0] e_vec, a_vec;

  always @(negedge clk) begin
    if (chk_en) begin
      e_done = m_act && (m_t == FL);
      e_clk  = m_act && (m_t < SH) && (((m_t / CD) % 2) == 1);
      e_lat  = m_act && (m_t >= SH) && (m_t < FL);
      e_data = (m_act && m_t < SH) ? m_cur[23 - m_t / (2 * CD)] : 1'b0;
      e_vec  = {e_data, e_clk, e_lat, m_act, e_done};
      a_vec  = {sr_data, sr_clk, sr_latch, busy, frame_done};
      tests++;
      if (a_vec !== e_vec || overrun !== 8'(m_ovr)) begin
        fails++;
        if (nprint < 10) begin
          nprint++;
          $display("FAIL model t=%0d: got %b/%0d expected %b/%0d",
                   m_t, a_vec, overrun, e_vec, m_ovr);
        end
      end
    end
  end

  // Frame monitor: bits on sr_clk rising edges, latch width, per frame.
  typedef struct {
    int          edges;
    logic [23:0] word;
    int          lat;
  } frame_t;

  frame_t      frames[$];
  int          mon_edges = 0;
  int          mon_lat = 0;
  logic [23:0] mon_bits = '0;
  logic        pclk = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      mon_edges = 0; mon_lat = 0; mon_bits = '0; pclk = 1'b0;
    end else begin
      if (sr_clk && !pclk) begin
        mon_bits = {mon_bits[22:0], sr_data};
        mon_edges++;
      end
      if (sr_latch) mon_lat++;
      if (frame_done) begin
        frames.push_back('{mon_edges, mon_bits, mon_lat});
        mon_edges = 0; mon_bits = '0; mon_lat = 0;
      end
      pclk = sr_clk;
    end
  end

  task automatic req(input logic [23:0] w);
    snap_req = 1'b1;
    {out_in, stack_in} = w;
    @(negedge clk);
    snap_req = 1'b0;
  endtask

  task automatic wait_done(output int n, input int budget);
    n = 0;
    while (!frame_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!frame_done) begin
      fails++;
      $display("FAIL done_timeout: got no frame_done expected one");
    end
  endtask

  task automatic expect_frame(input string name, input logic [23:0] w);
    frame_t f;
    #1;
    if (frames.size() == 0) begin
      check({name, " present"}, 0, 1);
    end else begin
      f = frames.pop_front();
      check({name, " word"}, f.word, w);
      check({name, " edges"}, f.edges, NB);
      check({name, " latch"}, f.lat, CD);
    end
  endtask

  typedef struct {
    logic [7:0]  o;
    logic [15:0] s;
    logic [23:0] w;
  } vec_t;

  vec_t vt[5];

  initial begin
    int n;
    int cnt;
    logic ok;
    logic ec, ed, el, edn;

    vt[0] = '{8'hA5, 16'h3C0F, 24'hA53C0F};
    vt[1] = '{8'h00, 16'h0000, 24'h000000};
    vt[2] = '{8'hFF, 16'hFFFF, 24'hFFFFFF};
    vt[3] = '{8'h80, 16'h0001, 24'h800001};
    vt[4] = '{8'h12, 16'h3456, 24'h123456};

    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rst2 = 1'b0;
    check("reset outs", {sr_data, sr_clk, sr_latch, busy, frame_done}, 0);
    check("reset ovr", overrun, 0);

    foreach (vt[i]) begin
      frames.delete();
      snap_req = 1'b1;
      out_in = vt[i].o;
      stack_in = vt[i].s;
      @(negedge clk);
      snap_req = 1'b0;
      check("tbl busy rise", busy, 1);
      wait_done(n, 200);
      check("tbl len", n, FL);
      expect_frame("tbl", vt[i].w);
      @(negedge clk);
      check("tbl idle", busy, 0);
      @(negedge clk);
    end

    // Back-to-back: second request at cycle 10 of frame 1.
    frames.delete();
    req(24'hA53C0F);
    repeat (10) @(negedge clk);
    req(24'h123456);
    wait_done(n, 200);
    @(negedge clk);
    check("b2b busy held", busy, 1);
    wait_done(n, 200);
    check("b2b len2", n, FL);
    expect_frame("b2b f1", 24'hA53C0F);
    expect_frame("b2b f2", 24'h123456);
    check("b2b ovr", overrun, 0);
    @(negedge clk);

    // Three requests during one frame.
    frames.delete();
    req(24'h111111);
    repeat (5) @(negedge clk);
    req(24'h222222);
    repeat (5) @(negedge clk);
    req(24'h333333);
    repeat (5) @(negedge clk);
    req(24'h444444);
    wait_done(n, 200);
    check("ovr two", overrun, 2);
    @(negedge clk);
    wait_done(n, 200);
    expect_frame("ovr f1", 24'h111111);
    expect_frame("ovr f2", 24'h444444);

    // Continuous requests drive the counter into saturation.
    snap_req = 1'b1;
    for (int i = 0; i < 500; i++) begin
      {out_in, stack_in} = 24'($urandom);
      @(negedge clk);
    end
    snap_req = 1'b0;
    check("ovr sat", overrun, 255);

    // Reset at bit 10 of the frame in flight.
    n = 0;
    while (mon_edges != 10 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("bit10 reached", mon_edges, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid rst outs",
          {sr_data, sr_clk, sr_latch, busy, frame_done}, 0);
    check("mid rst ovr", overrun, 0);
    frames.delete();
    cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (sr_latch || frame_done || busy) cnt++;
    end
    check("post rst quiet", cnt, 0);
    req(24'h5A5A5A);
    wait_done(n, 200);
    check("post rst len", n, FL);
    expect_frame("post rst", 24'h5A5A5A);
    @(negedge clk);

    // Request coincident with frame_done, pending empty.
    frames.delete();
    req(24'hC0FFEE);
    wait_done(n, 200);
    req(24'hBEEF01);
    check("sim0 busy", busy, 1);
    wait_done(n, 200);
    check("sim0 len", n, FL);
    expect_frame("sim0 a", 24'hC0FFEE);
    expect_frame("sim0 b", 24'hBEEF01);
    check("sim0 ovr", overrun, 0);
    @(negedge clk);
    check("sim0 idle", busy, 0);

    // Request coincident with frame_done, pending full.
    frames.delete();
    req(24'hAAAA01);
    repeat (5) @(negedge clk);
    req(24'hBBBB02);
    wait_done(n, 200);
    req(24'hCCCC03);
    wait_done(n, 200);
    @(negedge clk);
    wait_done(n, 200);
    expect_frame("sim1 a", 24'hAAAA01);
    expect_frame("sim1 b", 24'hBBBB02);
    expect_frame("sim1 c", 24'hCCCC03);
    check("sim1 ovr", overrun, 0);
    @(negedge clk);
    @(negedge clk);
    check("sim1 idle", busy, 0);

    // Random traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      snap_req = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 999) == 0);
      {out_in, stack_in} = 24'($urandom);
      @(negedge clk);
    end
    snap_req = 1'b0;
    rst = 1'b0;
    repeat (300) @(negedge clk);

    // CLK_DIV=1 corner on the second instance.
    snap2 = 1'b1;
    {out2, stk2} = 24'hFFFFFF;
    @(negedge clk);
    snap2 = 1'b0;
    ok = 1'b1;
    for (int t = 0; t <= 49; t++) begin
      ec  = (t < 48) && (t % 2 == 1);
      ed  = (t < 48);
      el  = (t == 48);
      edn = (t == 49);
      if ({d2, c2, l2, dn2, b2} !== {ed, ec, el, edn, 1'b1}) ok = 1'b0;
      @(negedge clk);
    end
    check("cd1 frame", ok, 1);
    check("cd1 idle", b2, 0);
    check("cd1 ovr", ovr2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
